// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and FSM state definitions for the ALU sequencer and its divider.
package alu_sequencer_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_DIV  = 4'd4,
    OP_MOD  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_NAND = 4'd10,
    OP_NOR  = 4'd11,
    OP_XNOR = 4'd12,
    OP_SHL  = 4'd13,
    OP_SHR  = 4'd14,
    OP_CLR  = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIVIDE,
    S_DONE
  } state_t;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider: the start edge computes the first quotient bit, then one
// bit per cycle; done rises after the WIDTH-th bit and holds until the next start.
module alu_div_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } step_t;

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt;
  logic             running;
  step_t            first_step, next_step;

  // quo holds the unconsumed dividend bits on top and new quotient bits below
  function automatic step_t step(input logic [WIDTH-1:0] rem,
                                 input logic [WIDTH-1:0] quo,
                                 input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    step_t          r;
    sh    = {rem, quo[WIDTH-1]};
    r.quo = {quo[WIDTH-2:0], 1'b0};
    r.rem = sh[WIDTH-1:0];
    if (sh >= {1'b0, d}) begin
      r.rem    = sh[WIDTH-1:0] - d;
      r.quo[0] = 1'b1;
    end
    return r;
  endfunction

  assign first_step = step('0, dividend, divisor);
  assign next_step  = step(rem_q, quo_q, div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      rem_q   <= first_step.rem;
      quo_q   <= first_step.quo;
      div_q   <= divisor;
      cnt     <= CW'(1);
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      rem_q <= next_step.rem;
      quo_q <= next_step.quo;
      cnt   <= cnt + CW'(1);
      if (cnt == CW'(WIDTH - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller with valid/ready command/result handshakes and accumulator.
// Optional ALU_SEQ_STATS_EN adds saturating completion/error counters (stat_ops, stat_errs).
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic               cmd_use_acc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               err_ovf,
  output logic               err_dz,
  output logic [2*WIDTH-1:0] acc,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]        stat_ops,
  output logic [15:0]        stat_errs,
`endif
  output logic               busy
);

  state_t             state, state_nxt;
  op_t                op_q, op_in;
  logic [WIDTH-1:0]   a_q, b_q, a_in, sum;
  logic [WIDTH-1:0]   quotient, remainder;
  logic [2*WIDTH-1:0] exec_res, div_res;
  logic               exec_ovf, exec_dz, exec_acc_we;
  logic               div_go, div_done, complete;

  assign op_in     = op_t'(cmd_op);
  assign a_in      = cmd_use_acc ? acc[WIDTH-1:0] : cmd_a;
  assign div_go    = (state == S_IDLE) && cmd_valid && is_div_op(op_in) && (cmd_b != '0);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign complete  = (state == S_DONE) && res_valid && res_ready;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_go),
    .dividend  (a_in),
    .divisor   (cmd_b),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (div_done)
  );

  assign div_res = (op_q == OP_MOD) ? {{WIDTH{1'b0}}, remainder} : {{WIDTH{1'b0}}, quotient};

  always_comb begin
    sum         = '0;
    exec_res    = '0;
    exec_ovf    = 1'b0;
    exec_dz     = 1'b0;
    exec_acc_we = 1'b1;
    case (op_q)
      OP_NOP: begin
        exec_res    = acc;
        exec_acc_we = 1'b0;
      end
      OP_ADD: begin
        sum      = a_q + b_q;
        exec_res = {{WIDTH{sum[WIDTH-1]}}, sum};
        exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sum      = a_q - b_q;
        exec_res = {{WIDTH{sum[WIDTH-1]}}, sum};
        exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL:  exec_res = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      // divide ops only reach EXEC with a zero divisor
      OP_DIV, OP_MOD: begin
        exec_dz     = 1'b1;
        exec_acc_we = 1'b0;
      end
      OP_AND:  exec_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   exec_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  exec_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_NOT:  exec_res = {{WIDTH{1'b0}}, ~a_q};
      OP_NAND: exec_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_NOR:  exec_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_XNOR: exec_res = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
      OP_SHL:  exec_res = {{WIDTH{1'b0}}, a_q} << b_q[SHW-1:0];
      OP_SHR:  exec_res = {{WIDTH{1'b0}}, a_q >> b_q[SHW-1:0]};
      OP_CLR:  exec_res = '0;
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = div_go ? S_DIVIDE : S_EXEC;
      S_EXEC:   state_nxt = S_DONE;
      S_DIVIDE: if (div_done) state_nxt = S_DONE;
      S_DONE:   if (res_valid && res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // res_valid is registered, so it rises one cycle after DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NOP;
      a_q       <= '0;
      b_q       <= '0;
      res_data  <= '0;
      err_ovf   <= 1'b0;
      err_dz    <= 1'b0;
      acc       <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q    <= op_in;
          a_q     <= a_in;
          b_q     <= cmd_b;
          err_ovf <= 1'b0;
          err_dz  <= 1'b0;
        end
        S_EXEC: begin
          res_data <= exec_res;
          err_ovf  <= exec_ovf;
          err_dz   <= exec_dz;
          if (exec_acc_we) acc <= exec_res;
        end
        S_DIVIDE: if (div_done) begin
          res_data <= div_res;
          acc      <= div_res;
        end
        S_DONE:  res_valid <= !(res_valid && res_ready);
        default: res_valid <= 1'b0;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state == S_EXEC && op_q == OP_CLR)) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (complete) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
      if ((err_ovf || err_dz) && stat_errs != '1) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a queue scoreboard and handshake monitor.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_use_acc = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        err_ovf, err_dz;
  logic [31:0] acc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    logic [31:0] accv;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .SHW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .err_ovf     (err_ovf),
    .err_dz      (err_dz),
    .acc         (acc),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_res"}, res_data, e.res);
          chk({e.name, "_ovf"}, {31'd0, err_ovf}, {31'd0, e.ovf});
          chk({e.name, "_dz"},  {31'd0, err_dz},  {31'd0, e.dz});
          chk({e.name, "_acc"}, acc, e.accv);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ua, input int lat,
                       input logic [31:0] res, input logic ovf, input logic dz,
                       input logic [31:0] accv);
    exp_t e;
    int   n = 0;
    wait_ready(name);
    e.name = name; e.res = res; e.ovf = ovf; e.dz = dz; e.accv = accv;
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_use_acc = 1'b0;
    while (!res_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    // Reset state
    @(posedge clk);
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_acc",       acc,                32'd0);
    chk("rst_res_data",  res_data,           32'd0);
    chk("rst_flags",     {30'd0, err_ovf, err_dz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 2,  32'hFFFF8000, 1'b1, 1'b0, 32'hFFFF8000);
    issue("mul",      OP_MUL, 16'h000A, 16'h000A, 1'b0, 2,  32'h00000064, 1'b0, 1'b0, 32'h00000064);
    issue("add_acc",  OP_ADD, 16'hBEEF, 16'h0006, 1'b1, 2,  32'h0000006A, 1'b0, 1'b0, 32'h0000006A);
    issue("div",      OP_DIV, 16'h0064, 16'h0007, 1'b0, 17, 32'h0000000E, 1'b0, 1'b0, 32'h0000000E);
    issue("mod",      OP_MOD, 16'h0064, 16'h0007, 1'b0, 17, 32'h00000002, 1'b0, 1'b0, 32'h00000002);
    issue("div_zero", OP_DIV, 16'h1234, 16'h0000, 1'b0, 2,  32'h00000000, 1'b0, 1'b1, 32'h00000002);
    issue("mod_zero", OP_MOD, 16'h0009, 16'h0000, 1'b0, 2,  32'h00000000, 1'b0, 1'b1, 32'h00000002);
    issue("mul_max",  OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 2,  32'hFFFE0001, 1'b0, 1'b0, 32'hFFFE0001);
    issue("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1'b0, 2,  32'h00007FFF, 1'b1, 1'b0, 32'h00007FFF);
    issue("sub_neg",  OP_SUB, 16'h0003, 16'h0005, 1'b0, 2,  32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFFE);
    issue("and",      OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 2,  32'h0000F000, 1'b0, 1'b0, 32'h0000F000);
    issue("not",      OP_NOT, 16'h00FF, 16'h1234, 1'b0, 2,  32'h0000FF00, 1'b0, 1'b0, 32'h0000FF00);
    issue("xnor",     OP_XNOR,16'h00FF, 16'h0F0F, 1'b0, 2,  32'h0000F00F, 1'b0, 1'b0, 32'h0000F00F);
    issue("shr",      OP_SHR, 16'h8000, 16'h000F, 1'b0, 2,  32'h00000001, 1'b0, 1'b0, 32'h00000001);
    issue("nop",      OP_NOP, 16'h5555, 16'hAAAA, 1'b0, 2,  32'h00000001, 1'b0, 1'b0, 32'h00000001);

    // Result must hold while the consumer stalls
    wait_ready("shl_pre");
    res_ready = 1'b0;
    issue("shl",      OP_SHL, 16'h8001, 16'h0004, 1'b0, 2,  32'h00080010, 1'b0, 1'b0, 32'h00080010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data",  res_data,           32'h00080010);
      chk("hold_flags", {30'd0, err_ovf, err_dz}, 32'd0);
      chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
    end
    res_ready = 1'b1;
    issue("clr",      OP_CLR, 16'hFFFF, 16'hFFFF, 1'b0, 2,  32'h00000000, 1'b0, 1'b0, 32'h00000000);
    issue("add_small",OP_ADD, 16'h0010, 16'h0020, 1'b0, 2,  32'h00000030, 1'b0, 1'b0, 32'h00000030);

    // Reset in the middle of a divide discards it
    wait_ready("div_rst");
    cmd_valid = 1'b1; cmd_op = OP_DIV; cmd_a = 16'h0064; cmd_b = 16'h0007;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_div_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_acc",       acc,                32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    issue("add_after_rst", OP_ADD, 16'h0002, 16'h0003, 1'b0, 2, 32'h00000005, 1'b0, 1'b0, 32'h00000005);

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
